// File: rtl/adc_trigger_axil_slave.sv
// AXI4-Lite register slave for the ADC trigger IP: config registers, trigger flag/counter
// with W1C status, and independent single-outstanding read and write channels.
module adc_trigger_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              trig_event,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     level_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     holdoff_reg,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     aux_reg,
    output logic                              irq
);

    typedef enum logic { WR_IDLE, WR_RESP } wr_state_e;
    typedef enum logic { RD_IDLE, RD_RESP } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic        rdy_en_q;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [2:0]  awidx_q, awidx_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] ctrl_q, ctrl_d, level_q, level_d, holdoff_q, holdoff_d, aux_q, aux_d;
    logic        flag_q, flag_d;
    logic [15:0] cnt_q, cnt_d;

    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [2:0]  wr_idx, rd_idx;
    logic [31:0] wr_data, rd_mux;
    logic [3:0]  wr_strb;

    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
        return r;
    endfunction

    assign S_AXI_BVALID  = (wr_state_q == WR_RESP);
    assign S_AXI_RVALID  = (rd_state_q == RD_RESP);
    assign S_AXI_AWREADY = rdy_en_q & ~aw_held_q & ~S_AXI_BVALID;
    assign S_AXI_WREADY  = rdy_en_q & ~w_held_q & ~S_AXI_BVALID;
    assign S_AXI_ARREADY = rdy_en_q & ~S_AXI_RVALID;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_hs   = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs    = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs   = S_AXI_ARVALID & S_AXI_ARREADY;
    // A held beat takes priority; otherwise use the beat handshaking this cycle.
    assign wr_idx  = aw_held_q ? awidx_q : S_AXI_AWADDR[4:2];
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
    assign wr_fire = (wr_state_q == WR_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign rd_idx  = S_AXI_ARADDR[4:2];

    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awidx_d    = awidx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awidx_d   = S_AXI_AWADDR[4:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = S_AXI_WDATA;
                    wstrb_d  = S_AXI_WSTRB;
                end
                if (wr_fire) begin
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                    wr_state_d = WR_RESP;
                    bresp_d    = (wr_idx > 3'd4) ? RESP_SLVERR : RESP_OKAY;
                end
            end
            WR_RESP: if (S_AXI_BREADY) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Register file; trigger set/increment is applied after W1C so the event wins.
    always_comb begin
        ctrl_d    = ctrl_q;
        level_d   = level_q;
        holdoff_d = holdoff_q;
        aux_d     = aux_q;
        flag_d    = flag_q;
        cnt_d     = cnt_q;
        if (wr_fire) begin
            case (wr_idx)
                3'd0: ctrl_d    = merge(ctrl_q, wr_data, wr_strb);
                3'd1: level_d   = merge(level_q, wr_data, wr_strb);
                3'd2: holdoff_d = merge(holdoff_q, wr_data, wr_strb);
                3'd3: aux_d     = merge(aux_q, wr_data, wr_strb);
                3'd4: if (wr_strb[0]) begin
                    if (wr_data[0]) flag_d = 1'b0;
                    if (wr_data[1]) cnt_d  = 16'd0;
                end
                default: ;
            endcase
        end
        if (trig_event) begin
            flag_d = 1'b1;
            if (ctrl_q[0] && cnt_d != 16'hFFFF) cnt_d = cnt_d + 16'd1;
        end
    end

    always_comb begin
        rd_mux = 32'd0;
        case (rd_idx)
            3'd0:    rd_mux = ctrl_q;
            3'd1:    rd_mux = level_q;
            3'd2:    rd_mux = holdoff_q;
            3'd3:    rd_mux = aux_q;
            3'd4:    rd_mux = {cnt_q, 15'd0, flag_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_IDLE: if (ar_hs) begin
                rd_state_d = RD_RESP;
                rdata_d    = rd_mux;
                rresp_d    = (rd_idx > 3'd4) ? RESP_SLVERR : RESP_OKAY;
            end
            RD_RESP: if (S_AXI_RREADY) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            rdy_en_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= 3'd0;
            wdata_q    <= 32'd0;
            wstrb_q    <= 4'd0;
            bresp_q    <= 2'd0;
            rresp_q    <= 2'd0;
            rdata_q    <= 32'd0;
            ctrl_q     <= 32'd0;
            level_q    <= 32'd0;
            holdoff_q  <= 32'd0;
            aux_q      <= 32'd0;
            flag_q     <= 1'b0;
            cnt_q      <= 16'd0;
        end else begin
            rdy_en_q   <= 1'b1;
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awidx_q    <= awidx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            level_q    <= level_d;
            holdoff_q  <= holdoff_d;
            aux_q      <= aux_d;
            flag_q     <= flag_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ctrl_reg    = ctrl_q;
    assign level_reg   = level_q;
    assign holdoff_reg = holdoff_q;
    assign aux_reg     = aux_q;
    assign irq         = flag_q & ctrl_q[1];

endmodule

// File: tb/tb_adc_trigger_axil_slave.sv
// Bench for adc_trigger_axil_slave: directed scenarios plus randomized traffic against
// a register-map model.
module tb_adc_trigger_axil_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready, trig;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata, ctrl_o, level_o, holdoff_o, aux_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [31:0] m_reg [4];
    bit          m_flag;
    int          m_cnt;

    always #5 clk = ~clk;

    adc_trigger_axil_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'd0), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'd0), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .trig_event(trig), .ctrl_reg(ctrl_o), .level_reg(level_o), .holdoff_reg(holdoff_o),
        .aux_reg(aux_o), .irq(irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 4; i++) m_reg[i] = 32'd0;
        m_flag = 0;
        m_cnt  = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] addr);
        int idx = int'(addr) / 4;
        if (idx < 4)  return m_reg[idx];
        if (idx == 4) return {m_cnt[15:0], 15'd0, m_flag};
        return 32'd0;
    endfunction

    function automatic logic [1:0] m_resp(input logic [4:0] addr);
        return (int'(addr) / 4 > 4) ? 2'b10 : 2'b00;
    endfunction

    task automatic m_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(addr) / 4;
        if (idx < 4) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) m_reg[idx][8*b +: 8] = d[8*b +: 8];
        end else if (idx == 4 && s[0]) begin
            if (d[0]) m_flag = 0;
            if (d[1]) m_cnt  = 0;
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".ctrl"}, ctrl_o, m_reg[0]);
        chk({tag, ".level"}, level_o, m_reg[1]);
        chk({tag, ".holdoff"}, holdoff_o, m_reg[2]);
        chk({tag, ".aux"}, aux_o, m_reg[3]);
        chk({tag, ".irq"}, 32'(irq), 32'(m_flag & m_reg[0][1]));
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] d, input logic [3:0] s,
                             input int aw_lead, input int w_lead, input int bdly);
        bit aw_done = 0, w_done = 0, awf, wf;
        int cyc = 0;
        logic [1:0] resp;
        awaddr = addr; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 50) begin
            awvalid = !aw_done && cyc >= aw_lead;
            wvalid  = !w_done && cyc >= w_lead;
            #1;
            awf = awvalid && awready;
            wf  = wvalid && wready;
            @(posedge clk); @(negedge clk);
            aw_done |= awf; w_done |= wf; cyc++;
        end
        awvalid = 0; wvalid = 0;
        chk("wr_hs", 32'({aw_done, w_done}), 32'd3);
        chk("bvalid_lat", 32'(bvalid), 32'd1);
        resp = bresp;
        for (int i = 0; i < bdly; i++) begin
            @(negedge clk);
            chk("bvalid_hold", 32'(bvalid), 32'd1);
            chk("bresp_hold", 32'(bresp), 32'(resp));
            chk("no_accept", 32'({awready, wready}), 32'd0);
        end
        m_write(addr, d, s);
        chk("bresp", 32'(bresp), 32'(m_resp(addr)));
        bready = 1;
        @(posedge clk); @(negedge clk);
        bready = 0;
        chk("bvalid_drop", 32'(bvalid), 32'd0);
    endtask

    task automatic axi_read(input logic [4:0] addr, input int rdly, output logic [31:0] d);
        int to = 0;
        logic [31:0] exp_d = m_read(addr);
        araddr = addr; arvalid = 1;
        #1;
        while (!arready && to < 20) begin
            @(negedge clk); #1; to++;
        end
        chk("ar_hs", 32'(arready), 32'd1);
        @(posedge clk); @(negedge clk);
        arvalid = 0;
        chk("rvalid_lat", 32'(rvalid), 32'd1);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("rvalid_hold", 32'(rvalid), 32'd1);
            chk("rdata_hold", rdata, exp_d);
        end
        d = rdata;
        chk("rresp", 32'(rresp), 32'(m_resp(addr)));
        chk("rdata", rdata, exp_d);
        rready = 1;
        @(posedge clk); @(negedge clk);
        rready = 0;
        chk("rvalid_drop", 32'(rvalid), 32'd0);
    endtask

    task automatic pulse();
        trig = 1;
        @(posedge clk); @(negedge clk);
        trig = 0;
        m_flag = 1;
        if (m_reg[0][0] && m_cnt < 65535) m_cnt++;
    endtask

    initial begin
        logic [31:0] rd;
        rst = 1; awaddr = 0; araddr = 0; awvalid = 0; wvalid = 0; bready = 0;
        arvalid = 0; rready = 0; trig = 0; wdata = 0; wstrb = 0;
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst.ready", 32'({awready, wready, arready}), 32'd0);
        chk("rst.valid", 32'({bvalid, rvalid}), 32'd0);
        chk("rst.rdata", rdata, 32'd0);
        chk_outs("rst");
        rst = 0;
        #1 chk("rdy_en.pre", 32'(arready), 32'd0);
        @(negedge clk);
        chk("rdy_en.post", 32'({awready, wready, arready}), 32'd7);

        // Basic write then readback
        for (int i = 0; i < 4; i++) axi_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
        chk_outs("basic");
        for (int i = 0; i < 4; i++) begin
            axi_read(5'(4 * i), 0, rd);
            chk("basic.rd", rd, 32'(i + 1));
        end

        // W leads AW by 3, BREADY held off 4 cycles
        axi_write(5'h08, 32'h1234_5678, 4'hF, 3, 0, 4);
        chk("wlead.holdoff", holdoff_o, 32'h1234_5678);

        // Byte-lane strobe
        axi_write(5'h04, 32'd0, 4'hF, 0, 0, 0);
        axi_write(5'h04, 32'hAABB_CCDD, 4'b0010, 1, 0, 1);
        axi_read(5'h04, 2, rd);
        chk("strb.level", rd, 32'h0000_CC00);

        // Trigger events, irq, W1C
        axi_write(5'h00, 32'h3, 4'hF, 0, 0, 0);
        repeat (3) pulse();
        axi_read(5'h10, 0, rd);
        chk("trig.status", rd, 32'h0003_0001);
        chk("trig.irq", 32'(irq), 32'd1);
        axi_write(5'h10, 32'h3, 4'h1, 0, 2, 0);
        axi_read(5'h10, 0, rd);
        chk("w1c.status", rd, 32'd0);
        chk("w1c.irq", 32'(irq), 32'd0);

        // Unmapped
        axi_read(5'h18, 1, rd);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        chk_outs("unmapped");

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int op = $urandom_range(0, 9);
            logic [4:0] a = 5'($urandom_range(0, 31));
            if (op < 4)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2));
            else if (op < 8)
                axi_read(a, $urandom_range(0, 2), rd);
            else
                repeat ($urandom_range(1, 3)) pulse();
            chk_outs("rand");
        end

        // Reset with a pending read response
        axi_write(5'h00, 32'h5, 4'hF, 0, 0, 0);
        araddr = 5'h00; arvalid = 1;
        #1 chk("rst6.ar", 32'(arready), 32'd1);
        @(posedge clk); @(negedge clk);
        arvalid = 0;
        chk("rst6.rvalid", 32'(rvalid), 32'd1);
        rst = 1;
        #1;
        chk("rst6.rvalid_async", 32'(rvalid), 32'd0);
        chk("rst6.ctrl", ctrl_o, 32'd0);
        m_reset();
        @(negedge clk); @(negedge clk);
        chk("rst6.ready", 32'({awready, wready, arready}), 32'd0);
        rst = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst6.no_stale", 32'({rvalid, bvalid}), 32'd0);
        end
        chk_outs("rst6");
        axi_read(5'h00, 0, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
